mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Multi-cycle data-memory access controller for the MIPS datapath; successor to the single-cycle memRead/memWrite decoder. Decodes load/store opcodes (LB/LBU/LH/LHU/LW/SB/SH/SW), drives a req/ready data-memory handshake with byte enables and lane-replicated store data, and stalls the pipeline until the access completes. Returns sign/zero-extended load data and flags bus timeouts.

Parameters:
ADDR_W, 32, width of the byte address presented to data memory.
TIMEOUT, 16, max cycles in ACCESS waiting for mem_ready before bus error; 0 = never time out.
CNT_W, 8, width of the wait counter; must hold TIMEOUT.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
issue_valid  input  1  MEM stage holds a valid instruction
instruction  input  32  instruction in MEM stage; opcode = bits [31:26]
addr  input  ADDR_W  effective byte address
store_data  input  32  rt value for stores
stall  output  1  hold pipeline
done  output  1  one-cycle completion pulse
load_data  output  32  extended load result, valid while done=1
bus_err  output  1  one-cycle timeout pulse, coincident with done
align_err  output  1  misalignment pulse (see Optional Feature)
mem_req  output  1  request to data memory
mem_we  output  1  1 = write
mem_be  output  4  byte enables
mem_addr  output  ADDR_W  word-aligned address (low 2 bits 0)
mem_wdata  output  32  lane-replicated store data
mem_ready  input  1  memory accepts/completes the request at this edge
mem_rdata  input  32  read word, valid when mem_ready=1

Behaviour:
- Clock is clk; reset is rst_n, asynchronous, active-low. Reset: state IDLE, counter 0; stall, done, load_data, bus_err, align_err, mem_req, mem_we, mem_be, mem_addr, mem_wdata all 0.
- Reset mid-access: mem_req drops immediately, transaction discarded, no done.
- States: IDLE, ACCESS, DONE.
- Accept: in IDLE or DONE, issue_valid=1 and opcode is one of the eight memory opcodes. Non-memory opcodes: ignored, no stall, no request.
- stall is combinational: 1 in the accept cycle and throughout ACCESS; 0 in IDLE without accept and in DONE without a new accept.
- On accept edge: latch opcode, addr[1:0], store data; register mem_req=1, mem_we, mem_be, mem_addr={addr[ADDR_W-1:2],2'b00}, mem_wdata; go to ACCESS; counter cleared.
- ACCESS: mem_req and all mem_* held stable until an edge with mem_ready=1. That edge: capture extended load data (stores: load_data=0), mem_req=0, go to DONE. Minimum latency accept→done = 2 cycles.
- Timeout: counter increments each ACCESS cycle without ready; when it reaches TIMEOUT (TIMEOUT>0): mem_req=0, go to DONE with bus_err=1, load_data=0. mem_ready on the same edge as the limit wins (normal completion).
- DONE: done=1 for exactly one cycle; then IDLE, or ACCESS if a new accept occurs in that cycle (back-to-back).
- Byte enables: byte ops 4'b0001<<addr[1:0]; half ops addr[1]?4'b1100:4'b0011; word 4'b1111.
- Store data: SB {4{store_data[7:0]}}; SH {2{store_data[15:0]}}; SW store_data.
- Loads: select byte lane addr[1:0] / half lane addr[1] from mem_rdata (little-endian); LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.

Optional Feature:
MEM_ALIGN_CHECK_EN. Defined: accept of LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, issues no memory request, goes straight to DONE with done=1, align_err=1, load_data=0 (one stall cycle). Undefined: no check; half ops use addr[1] only, word ops ignore addr[1:0]; align_err tied 0.

Test Plan:
- Reset during ACCESS with mem_req=1: deassert rst_n mid-cycle → mem_req, stall drop to 0 immediately; no done after release.
- SB addr=0x1003 store_data=0x000000A5, mem_ready on first ACCESS cycle → mem_be=4'b1000, mem_wdata=0xA5A5A5A5, mem_addr=0x1000, mem_we=1, done 2 cycles after accept.
- LB addr=...2, mem_rdata=0x00800000 → load_data=0xFFFFFF80; LBU same → 0x00000080; LH addr=...2, mem_rdata=0x80010000 → 0xFFFF8001.
- LW with mem_ready held 0, TIMEOUT=16 → mem_req high 16 cycles, then done=1, bus_err=1, load_data=0, stall released.
- Back-to-back SW then LW, mem_ready after 3 wait cycles each → second accept in DONE cycle, no IDLE bubble, each done one cycle.
- With MEM_ALIGN_CHECK_EN, LW addr=0x2002 → mem_req never asserts, done=1 and align_err=1 one cycle after accept; without macro → request to 0x2000, be=4'b1111.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Multi-cycle data-memory access controller: decodes MIPS load/store opcodes, runs a req/ready
// handshake with a bus timeout, and stalls the pipeline. Optional misalignment trap: MEM_ALIGN_CHECK_EN.
module mem_access_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue_valid,
   input  logic [31:0]       instruction,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       store_data,
   output logic              stall,
   output logic              done,
   output logic [31:0]       load_data,
   output logic              bus_err,
   output logic              align_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ready,
   input  logic [31:0]       mem_rdata
);

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2B;

   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   function automatic logic [3:0] byte_enables(input logic [5:0] op, input logic [1:0] lo);
      case (op)
         OP_LB, OP_LBU, OP_SB: return 4'b0001 << lo;
         OP_LH, OP_LHU, OP_SH: return lo[1] ? 4'b1100 : 4'b0011;
         default:              return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] lane_wdata(input logic [5:0] op, input logic [31:0] sd);
      case (op)
         OP_SB:   return {4{sd[7:0]}};
         OP_SH:   return {2{sd[15:0]}};
         OP_SW:   return sd;
         default: return 32'h0;
      endcase
   endfunction

   // Little-endian lane select; anything that is not a load returns zero.
   function automatic logic [31:0] extract_load(input logic [5:0] op, input logic [1:0] lo,
                                                input logic [31:0] rdata);
      logic [7:0]  b;
      logic [15:0] h;
      b = rdata[{lo, 3'b000} +: 8];
      h = lo[1] ? rdata[31:16] : rdata[15:0];
      case (op)
         OP_LB:   return {{24{b[7]}}, b};
         OP_LBU:  return {24'h0, b};
         OP_LH:   return {{16{h[15]}}, h};
         OP_LHU:  return {16'h0, h};
         OP_LW:   return rdata;
         default: return 32'h0;
      endcase
   endfunction

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic [5:0]        op_q, op_d;
   logic [1:0]        lane_q, lane_d;
   logic              done_q, done_d;
   logic [31:0]       load_data_q, load_data_d;
   logic              bus_err_q, bus_err_d;
   logic              align_err_q, align_err_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [3:0]        mem_be_q, mem_be_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;

   logic [5:0] opcode;
   logic       is_mem_op, is_store_op, misaligned, accept;
   logic       unused_instr_bits;

   assign opcode            = instruction[31:26];
   assign unused_instr_bits = ^instruction[25:0];

   always_comb begin
      is_mem_op   = 1'b0;
      is_store_op = 1'b0;
      case (opcode)
         OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: is_mem_op = 1'b1;
         OP_SB, OP_SH, OP_SW: begin
            is_mem_op   = 1'b1;
            is_store_op = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef MEM_ALIGN_CHECK_EN
   always_comb begin
      case (opcode)
         OP_LH, OP_LHU, OP_SH: misaligned = addr[0];
         OP_LW, OP_SW:         misaligned = |addr[1:0];
         default:              misaligned = 1'b0;
      endcase
   end
`else
   assign misaligned = 1'b0;
`endif

   // Gating with rst_n keeps stall low while reset is held, even if issue_valid is high.
   assign accept  = rst_n && issue_valid && is_mem_op && (state_q != S_ACCESS);
   assign stall   = accept || (state_q == S_ACCESS);
   assign cnt_inc = cnt_q + 1'b1;

   always_comb begin
      // NOTE: every *_d gets a default first so no path through the case infers a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      lane_d      = lane_q;
      done_d      = 1'b0;
      load_data_d = load_data_q;
      bus_err_d   = 1'b0;
      align_err_d = 1'b0;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (accept && misaligned) begin
               state_d     = S_DONE;
               done_d      = 1'b1;
               align_err_d = 1'b1;
               load_data_d = 32'h0;
            end else if (accept) begin
               state_d     = S_ACCESS;
               cnt_d       = '0;
               op_d        = opcode;
               lane_d      = addr[1:0];
               mem_req_d   = 1'b1;
               mem_we_d    = is_store_op;
               mem_be_d    = byte_enables(opcode, addr[1:0]);
               mem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
               mem_wdata_d = lane_wdata(opcode, store_data);
            end
         end
         S_ACCESS: begin
            if (mem_ready) begin
               state_d     = S_DONE;
               done_d      = 1'b1;
               mem_req_d   = 1'b0;
               load_data_d = extract_load(op_q, lane_q, mem_rdata);
            end else if ((TIMEOUT != 0) && (cnt_inc == CNT_LIMIT)) begin
               state_d     = S_DONE;
               done_d      = 1'b1;
               bus_err_d   = 1'b1;
               mem_req_d   = 1'b0;
               load_data_d = 32'h0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         op_q        <= '0;
         lane_q      <= '0;
         done_q      <= 1'b0;
         load_data_q <= '0;
         bus_err_q   <= 1'b0;
         align_err_q <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         lane_q      <= lane_d;
         done_q      <= done_d;
         load_data_q <= load_data_d;
         bus_err_q   <= bus_err_d;
         align_err_q <= align_err_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign done      = done_q;
   assign load_data = load_data_q;
   assign bus_err   = bus_err_q;
   assign align_err = align_err_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_be    = mem_be_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized accesses
// compared against a byte-arithmetic reference model of the load/store rules.
module tb_mem_access_ctrl;

   localparam int ADDR_W  = 32;
   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              issue_valid = 1'b0;
   logic [31:0]       instruction = '0;
   logic [ADDR_W-1:0] addr = '0;
   logic [31:0]       store_data = '0;
   logic              stall, done, bus_err, align_err, mem_req, mem_we;
   logic [31:0]       load_data, mem_wdata;
   logic [3:0]        mem_be;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ready = 1'b0;
   logic [31:0]       mem_rdata = '0;

   int n_cmp = 0;
   int n_err = 0;

   mem_access_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .instruction(instruction),
      .addr(addr), .store_data(store_data), .stall(stall), .done(done),
      .load_data(load_data), .bus_err(bus_err), .align_err(align_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Reference model: access size in bytes, signedness and direction per opcode.
   function automatic int op_size(input logic [5:0] op);
      case (op)
         6'h20, 6'h24, 6'h28: return 1;
         6'h21, 6'h25, 6'h29: return 2;
         default:             return 4;
      endcase
   endfunction

   function automatic bit op_store(input logic [5:0] op);
      return (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
   endfunction

   function automatic bit op_signed(input logic [5:0] op);
      return (op == 6'h20) || (op == 6'h21);
   endfunction

   function automatic logic [3:0] model_be(input logic [5:0] op, input logic [31:0] a);
      int sz;
      sz = op_size(op);
      if (sz == 1) return 4'(1 << (a % 4));
      if (sz == 2) return 4'(3 << (2 * ((a / 2) % 2)));
      return 4'hF;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [5:0] op, input logic [31:0] sd);
      int sz;
      sz = op_size(op);
      if (sz == 1) return (sd % 256) * 32'h0101_0101;
      if (sz == 2) return (sd % 65536) * 32'h0001_0001;
      return sd;
   endfunction

   function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] a,
                                              input logic [31:0] rd);
      logic [31:0] v;
      int sz;
      sz = op_size(op);
      if (op_store(op)) return 32'h0;
      if (sz == 4) return rd;
      if (sz == 1) begin
         v = (rd >> (8 * (a % 4))) % 256;
         if (op_signed(op) && v >= 128) v = v - 256;
      end else begin
         v = (rd >> (16 * ((a / 2) % 2))) % 65536;
         if (op_signed(op) && v >= 32768) v = v - 65536;
      end
      return v;
   endfunction

   function automatic bit model_misaligned(input logic [5:0] op, input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
      if (op_size(op) == 2) return (a % 2) != 0;
      if (op_size(op) == 4) return (a % 4) != 0;
`endif
      return 1'b0;
   endfunction

   // Called at a negedge; accepts now and returns at the negedge of the done cycle.
   task automatic do_access(input string tag, input logic [5:0] op, input logic [31:0] a,
                            input logic [31:0] sd, input int wait_n, input logic [31:0] rd);
      logic [31:0] tmp;
      bit timeout;
      int n;
      tmp         = $urandom();
      instruction = {op, tmp[25:0]};
      addr        = a;
      store_data  = sd;
      issue_valid = 1'b1;
      #1 check({tag, ".accept_stall"}, 32'(stall), 32'd1);
      @(negedge clk);
      issue_valid = 1'b0;
      addr        = $urandom();
      store_data  = $urandom();
      if (model_misaligned(op, a)) begin
         check({tag, ".align_done"}, 32'(done), 32'd1);
         check({tag, ".align_err"}, 32'(align_err), 32'd1);
         check({tag, ".align_req"}, 32'(mem_req), 32'd0);
         check({tag, ".align_data"}, load_data, 32'h0);
         check({tag, ".align_stall"}, 32'(stall), 32'd0);
         return;
      end
      timeout = (TIMEOUT != 0) && (wait_n >= TIMEOUT);
      n = timeout ? TIMEOUT : wait_n + 1;
      for (int i = 0; i < n; i++) begin
         if (i > 0) @(negedge clk);
         check({tag, ".req"}, 32'(mem_req), 32'd1);
         check({tag, ".stall"}, 32'(stall), 32'd1);
         check({tag, ".no_done"}, 32'(done), 32'd0);
         check({tag, ".we"}, 32'(mem_we), 32'(op_store(op)));
         check({tag, ".be"}, 32'(mem_be), 32'(model_be(op, a)));
         check({tag, ".addr"}, mem_addr, a & ~32'h3);
         if (op_store(op)) check({tag, ".wdata"}, mem_wdata, model_wdata(op, sd));
         if (i == wait_n) begin
            mem_ready = 1'b1;
            mem_rdata = rd;
         end else begin
            mem_rdata = $urandom();
         end
      end
      @(negedge clk);
      check({tag, ".done"}, 32'(done), 32'd1);
      check({tag, ".bus_err"}, 32'(bus_err), 32'(timeout));
      check({tag, ".align_err"}, 32'(align_err), 32'd0);
      check({tag, ".load_data"}, load_data, timeout ? 32'h0 : model_load(op, a, rd));
      check({tag, ".req_drop"}, 32'(mem_req), 32'd0);
      check({tag, ".stall_rel"}, 32'(stall), 32'd0);
      mem_ready = 1'b0;
   endtask

   logic [5:0] op_tab [8] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};

   initial begin
      // Reset state
      #12;
      check("rst.stall", 32'(stall), 32'd0);
      check("rst.done", 32'(done), 32'd0);
      check("rst.load_data", load_data, 32'h0);
      check("rst.bus_err", 32'(bus_err), 32'd0);
      check("rst.align_err", 32'(align_err), 32'd0);
      check("rst.mem_req", 32'(mem_req), 32'd0);
      check("rst.mem_we", 32'(mem_we), 32'd0);
      check("rst.mem_be", 32'(mem_be), 32'd0);
      check("rst.mem_addr", mem_addr, 32'h0);
      check("rst.mem_wdata", mem_wdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Non-memory opcodes and an unqualified memory opcode are ignored
      issue_valid = 1'b1;
      instruction = {6'h00, 26'h0123456};
      #1 check("nonmem.rtype_stall", 32'(stall), 32'd0);
      @(negedge clk);
      check("nonmem.rtype_req", 32'(mem_req), 32'd0);
      instruction = {6'h22, 26'h0};
      #1 check("nonmem.lwl_stall", 32'(stall), 32'd0);
      @(negedge clk);
      check("nonmem.lwl_req", 32'(mem_req), 32'd0);
      issue_valid = 1'b0;
      instruction = {6'h23, 26'h0};
      #1 check("nonmem.invalid_stall", 32'(stall), 32'd0);
      @(negedge clk);
      check("nonmem.invalid_req", 32'(mem_req), 32'd0);
      check("nonmem.done", 32'(done), 32'd0);

      // Directed loads and stores
      do_access("sb_1003", 6'h28, 32'h0000_1003, 32'h0000_00A5, 0, 32'h0);
      @(negedge clk);
      do_access("lb_sign", 6'h20, 32'h0000_4002, 32'h0, 0, 32'h0080_0000);
      @(negedge clk);
      do_access("lbu_zero", 6'h24, 32'h0000_4002, 32'h0, 1, 32'h0080_0000);
      @(negedge clk);
      do_access("lh_sign", 6'h21, 32'h0000_4002, 32'h0, 2, 32'h8001_0000);
      @(negedge clk);
      do_access("lhu_lo", 6'h25, 32'h0000_4000, 32'h0, 0, 32'h1234_9ABC);
      @(negedge clk);
      do_access("sh_hi", 6'h29, 32'h0000_4002, 32'hDEAD_BEEF, 1, 32'h0);
      @(negedge clk);

      // Timeout, and ready arriving on the very edge of the limit
      do_access("lw_timeout", 6'h23, 32'h0000_5000, 32'h0, TIMEOUT + 4, 32'hCAFE_F00D);
      @(negedge clk);
      do_access("lw_ready_at_limit", 6'h23, 32'h0000_5004, 32'h0, TIMEOUT - 1, 32'hCAFE_F00D);
      @(negedge clk);

      // Back-to-back: second accept lands in the DONE cycle
      do_access("b2b_sw", 6'h2B, 32'h0000_6000, 32'h1122_3344, 3, 32'h0);
      do_access("b2b_lw", 6'h23, 32'h0000_6000, 32'h0, 3, 32'h5566_7788);
      @(negedge clk);
      check("b2b.idle_done", 32'(done), 32'd0);

      // Misaligned word: trapped with the check enabled, else issued to the aligned word
      do_access("lw_2002", 6'h23, 32'h0000_2002, 32'h0, 0, 32'h0BAD_F00D);
      @(negedge clk);
      check("lw_2002.idle_req", 32'(mem_req), 32'd0);

      // Randomized accesses, random waits, random gaps
      for (int k = 0; k < 40; k++) begin
         logic [5:0] op;
         int w;
         op = op_tab[$urandom_range(0, 7)];
         w  = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 2)
                                          : $urandom_range(0, 4);
         do_access("rand", op, $urandom(), $urandom(), w, $urandom());
         if ($urandom_range(0, 1) == 1) begin
            @(negedge clk);
            check("rand.gap_done", 32'(done), 32'd0);
         end
      end

      // Reset in the middle of an access
      @(negedge clk);
      instruction = {6'h23, 26'h0};
      addr        = 32'h0000_7000;
      issue_valid = 1'b1;
      @(negedge clk);
      issue_valid = 1'b0;
      check("midrst.req_before", 32'(mem_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst.req", 32'(mem_req), 32'd0);
      check("midrst.stall", 32'(stall), 32'd0);
      check("midrst.be", 32'(mem_be), 32'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      mem_ready = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("midrst.no_done", 32'(done), 32'd0);
         check("midrst.no_req", 32'(mem_req), 32'd0);
      end
      mem_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
